// File: rtl/if_id_stage.sv
// ============================================================================
//  Module   : if_id_stage
//  Purpose  : PC register and IF/ID pipeline register with stall, flush and
//             branch redirect. Optional stall counter: IF_STALL_COUNTER_EN.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module if_id_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] imem_rdata,
    input  logic        pc_write,
    input  logic        ifid_write,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] imem_addr,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc4,
    output logic        ifid_valid,
    output logic [7:0]  ifid_rs,
    output logic [7:0]  ifid_rt,
    output logic [15:0] stall_count
);

    localparam logic [31:0] c_pc_step = 32'd4;

    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;
    logic [31:0] pc_plus4;
    logic        unused_tgt_bits;

    assign pc_plus4        = pc_q + c_pc_step;
    assign unused_tgt_bits = ^branch_target[1:0];

    // Stall (ifid_write=0) wins over flush; pc_write=0 drops any redirect.
    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        if (pc_write) begin
            pc_d = branch_taken ? {branch_target[31:2], 2'b00} : pc_plus4;
        end
        if (ifid_write) begin
            if (branch_taken) begin
                instr_d = 32'h0000_0000;
                pc4_d   = 32'h0000_0000;
                valid_d = 1'b0;
            end else begin
                instr_d = imem_rdata;
                pc4_d   = pc_plus4;
                valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            instr_q <= 32'h0000_0000;
            pc4_q   <= 32'h0000_0000;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
        end
    end

    assign imem_addr  = pc_q;
    assign ifid_instr = instr_q;
    assign ifid_pc4   = pc4_q;
    assign ifid_valid = valid_q;
    assign ifid_rs    = valid_q ? {3'b000, instr_q[25:21]} : 8'h00;
    assign ifid_rt    = valid_q ? {3'b000, instr_q[20:16]} : 8'h00;

`ifdef IF_STALL_COUNTER_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!ifid_write && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= 16'h0000;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_count = stall_cnt_q;
`else
    assign stall_count = 16'h0000;
`endif

endmodule

`default_nettype wire

// File: tb/tb_if_id_stage.sv
// ============================================================================
//  Module   : tb_if_id_stage
//  Purpose  : Self-checking bench for if_id_stage using a scoreboard queue.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_if_id_stage;

    logic        clk;
    logic        rst_n;
    logic [31:0] imem_rdata;
    logic        pc_write;
    logic        ifid_write;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] imem_addr;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc4;
    logic        ifid_valid;
    logic [7:0]  ifid_rs;
    logic [7:0]  ifid_rt;
    logic [15:0] stall_count;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
        logic [15:0] sc;
    } exp_t;

    exp_t sb_q[$];

    // bench-side reference state
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_pc4;
    logic        m_valid;
    logic [15:0] m_sc;

    if_id_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_rdata   (imem_rdata),
        .pc_write     (pc_write),
        .ifid_write   (ifid_write),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .imem_addr    (imem_addr),
        .ifid_instr   (ifid_instr),
        .ifid_pc4     (ifid_pc4),
        .ifid_valid   (ifid_valid),
        .ifid_rs      (ifid_rs),
        .ifid_rt      (ifid_rt),
        .stall_count  (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h8C43_0004;
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    always_comb imem_rdata = mem_word(imem_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input exp_t e);
        logic [7:0] rs_e;
        logic [7:0] rt_e;
        rs_e = e.valid ? {3'b000, e.instr[25:21]} : 8'h00;
        rt_e = e.valid ? {3'b000, e.instr[20:16]} : 8'h00;
        chk({tag, ".pc"},    imem_addr,            e.pc);
        chk({tag, ".instr"}, ifid_instr,           e.instr);
        chk({tag, ".pc4"},   ifid_pc4,             e.pc4);
        chk({tag, ".valid"}, {31'b0, ifid_valid},  {31'b0, e.valid});
        chk({tag, ".rs"},    {24'b0, ifid_rs},     {24'b0, rs_e});
        chk({tag, ".rt"},    {24'b0, ifid_rt},     {24'b0, rt_e});
        chk({tag, ".sc"},    {16'b0, stall_count}, {16'b0, e.sc});
    endtask

    function automatic exp_t model_now();
        exp_t e;
        e.pc = m_pc; e.instr = m_instr; e.pc4 = m_pc4; e.valid = m_valid; e.sc = m_sc;
        return e;
    endfunction

    task automatic model_reset();
        m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_sc = 16'h0;
    endtask

    // Advance the reference model by one edge using the current inputs.
    task automatic model_edge();
        logic [31:0] word;
        logic [31:0] inc;
        word = mem_word(m_pc);
        inc  = m_pc + 32'd4;
        if (ifid_write) begin
            if (branch_taken) begin
                m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
            end else begin
                m_instr = word; m_pc4 = inc; m_valid = 1'b1;
            end
        end
`ifdef IF_STALL_COUNTER_EN
        if (!ifid_write && m_sc != 16'hFFFF) m_sc = m_sc + 16'd1;
`endif
        if (pc_write) m_pc = branch_taken ? {branch_target[31:2], 2'b00} : inc;
    endtask

    task automatic step(input string tag, input logic pw, input logic iw,
                        input logic br, input logic [31:0] tgt);
        exp_t e;
        pc_write = pw; ifid_write = iw; branch_taken = br; branch_target = tgt;
        model_edge();
        sb_q.push_back(model_now());
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL %s scoreboard empty observed=0 expected=1", tag);
        end else begin
            e = sb_q.pop_front();
            check_all(tag, e);
        end
    endtask

    initial begin
        exp_t e;
        rst_n = 1'b0; pc_write = 1'b0; ifid_write = 1'b0;
        branch_taken = 1'b0; branch_target = 32'h0;
        model_reset();
        #12;
        check_all("reset", model_now());

        @(negedge clk);
        rst_n = 1'b1;

        step("fetch0",  1'b1, 1'b1, 1'b0, 32'h0);
        chk("fetch0.abs_instr", ifid_instr, 32'h8C43_0004);
        chk("fetch0.abs_rs", {24'b0, ifid_rs}, 32'h2);
        chk("fetch0.abs_rt", {24'b0, ifid_rt}, 32'h3);
        step("fetch1",  1'b1, 1'b1, 1'b0, 32'h0);
        step("stall1",  1'b0, 1'b0, 1'b0, 32'h0);
        step("stall2",  1'b0, 1'b0, 1'b0, 32'h0);
        chk("stall2.abs_pc", imem_addr, 32'h8);
`ifdef IF_STALL_COUNTER_EN
        chk("stall2.abs_sc", {16'b0, stall_count}, 32'h2);
`endif
        step("stall_br", 1'b0, 1'b0, 1'b1, 32'h0000_1000);
        step("flush",    1'b1, 1'b1, 1'b1, 32'h0000_0043);
        chk("flush.abs_pc", imem_addr, 32'h40);
        step("after_fl", 1'b1, 1'b1, 1'b0, 32'h0);
        step("refetch",  1'b0, 1'b1, 1'b0, 32'h0);
        step("pc_only",  1'b1, 1'b0, 1'b0, 32'h0);
        step("to_top",   1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF);
        chk("to_top.abs_pc", imem_addr, 32'hFFFF_FFFC);
        step("wrap",     1'b1, 1'b1, 1'b0, 32'h0);
        chk("wrap.abs_pc",  imem_addr, 32'h0);
        chk("wrap.abs_pc4", ifid_pc4,  32'h0);
        step("mid_stall", 1'b0, 1'b0, 1'b1, 32'h0000_0200);

        // async reset between edges, no clock needed
        rst_n = 1'b0;
        #2;
        model_reset();
        check_all("async_rst", model_now());
        @(negedge clk);
        rst_n = 1'b1;
        step("post_rst", 1'b1, 1'b1, 1'b0, 32'h0);
        chk("post_rst.abs_pc", imem_addr, 32'h4);

`ifdef IF_STALL_COUNTER_EN
        pc_write = 1'b0; ifid_write = 1'b0; branch_taken = 1'b0;
        repeat (65540) model_edge();
        repeat (65540) @(posedge clk);
        #1;
        e = model_now();
        check_all("saturate", e);
        chk("saturate.abs_sc", {16'b0, stall_count}, 32'h0000_FFFF);
`endif

        if (sb_q.size() != 0) begin
            checks++; failures++;
            $display("FAIL scoreboard_leftover observed=%0d expected=0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
